ibex_rf_operand_fetch: RTL and testbench

IBEX_RF_OPERAND_FETCH -- requirements
Module: ibex_rf_operand_fetch

---
 rtl/ibex_rf_pkg.sv | 32 +++
 rtl/ibex_rf_opd_slot.sv | 53 +++++
 rtl/ibex_rf_operand_fetch.sv | 155 +++++++++++++++
 tb/tb_ibex_rf_operand_fetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rf_pkg.sv
// Shared types for the register-file operand fetch stage.
// Holds the FSM encoding and the L1/L2/zero address classification.
package ibex_rf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_L2 = 2'd1,
        HOLD    = 2'd2
    } rf_state_e;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_L1   = 2'd1,
        CLS_L2   = 2'd2
    } addr_cls_e;

    localparam logic [1:0] L1_REGION = 2'b01;

    // An unused operand behaves exactly like x0.
    function automatic addr_cls_e classify_addr(
        input logic [4:0] addr,
        input logic       used
    );
        if (!used || addr == 5'd0) begin
            return CLS_ZERO;
        end else if (addr[4:3] == L1_REGION) begin
            return CLS_L1;
        end
        return CLS_L2;
    endfunction

endpackage

// File: rtl/ibex_rf_opd_slot.sv
// One operand capture register with write-back snooping.
// Forwards a same-cycle write at capture and follows writes while held.
module ibex_rf_opd_slot
    import ibex_rf_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 capture_i,
    input  logic                 upd_en_i,
    input  logic [4:0]           cap_addr_i,
    input  logic                 cap_zero_i,
    input  logic [DataWidth-1:0] rf_rdata_i,
    input  logic                 wb_we_i,
    input  logic [4:0]           wb_waddr_i,
    input  logic [DataWidth-1:0] wb_wdata_i,
    output logic [DataWidth-1:0] data_o
);

    logic [DataWidth-1:0] data_q;
    logic [4:0]           addr_q;
    logic                 zero_q;
    logic                 cap_hit;
    logic                 hold_hit;

    // A zero operand never matches, which also covers writes to x0.
    assign cap_hit  = wb_we_i && !cap_zero_i && (wb_waddr_i == cap_addr_i);
    assign hold_hit = upd_en_i && wb_we_i && !zero_q && (wb_waddr_i == addr_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            addr_q <= '0;
            zero_q <= 1'b1;
        end else if (capture_i) begin
            addr_q <= cap_addr_i;
            zero_q <= cap_zero_i;
            if (cap_zero_i) begin
                data_q <= '0;
            end else if (cap_hit) begin
                data_q <= wb_wdata_i;
            end else begin
                data_q <= rf_rdata_i;
            end
        end else if (hold_hit) begin
            data_q <= wb_wdata_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/ibex_rf_operand_fetch.sv
// Operand fetch from a split L1/L2 SRAM register file.
// L1-only requests deliver after 1 cycle; any L2 operand adds one stall.
module ibex_rf_operand_fetch
    import ibex_rf_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    input  logic                 use_b_i,
    output logic [4:0]           rf_raddr_a_o,
    output logic [4:0]           rf_raddr_b_o,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    input  logic                 wb_we_i,
    input  logic [4:0]           wb_waddr_i,
    input  logic [DataWidth-1:0] wb_wdata_i,
    output logic                 opd_valid_o,
    input  logic                 opd_ready_i,
    output logic [DataWidth-1:0] opd_a_o,
    output logic [DataWidth-1:0] opd_b_o,
    output logic                 stall_o,
    output logic [CntWidth-1:0]  miss_cnt_o
);

    rf_state_e state_q, state_d;

    logic                accept;
    logic                need_l2;
    logic                in_wait;
    logic                capture;
    logic [4:0]          addr_a_q, addr_b_q;
    logic                use_b_q;
    logic [4:0]          cap_addr_a, cap_addr_b;
    logic                cap_use_b;
    logic                cap_zero_a, cap_zero_b;
    logic [CntWidth-1:0] miss_cnt_q;

    assign accept  = req_valid_i && req_ready_o;
    assign in_wait = (state_q == WAIT_L2);
    assign need_l2 = (classify_addr(raddr_a_i, 1'b1) == CLS_L2) ||
                     (classify_addr(raddr_b_i, use_b_i) == CLS_L2);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = need_l2 ? WAIT_L2 : HOLD;
            end
            WAIT_L2: state_d = HOLD;
            HOLD: begin
                if (accept) begin
                    state_d = need_l2 ? WAIT_L2 : HOLD;
                end else if (opd_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        stall_o     = 1'b0;
        opd_valid_o = 1'b0;
        unique case (state_q)
            IDLE:    req_ready_o = !rst_i;
            WAIT_L2: stall_o = 1'b1;
            HOLD: begin
                opd_valid_o = 1'b1;
                req_ready_o = opd_ready_i && !rst_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            use_b_q  <= 1'b0;
        end else if (accept) begin
            addr_a_q <= raddr_a_i;
            addr_b_q <= raddr_b_i;
            use_b_q  <= use_b_i;
        end
    end

    // The L2 SRAM needs the address held for the whole wait cycle.
    assign cap_addr_a   = in_wait ? addr_a_q : raddr_a_i;
    assign cap_addr_b   = in_wait ? addr_b_q : raddr_b_i;
    assign cap_use_b    = in_wait ? use_b_q  : use_b_i;
    assign rf_raddr_a_o = cap_addr_a;
    assign rf_raddr_b_o = cap_addr_b;

    assign cap_zero_a = (classify_addr(cap_addr_a, 1'b1) == CLS_ZERO);
    assign cap_zero_b = (classify_addr(cap_addr_b, cap_use_b) == CLS_ZERO);
    assign capture    = (accept && !need_l2) || in_wait;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            miss_cnt_q <= '0;
        end else if (accept && need_l2 && (miss_cnt_q != '1)) begin
            miss_cnt_q <= miss_cnt_q + CntWidth'(1);
        end
    end

    assign miss_cnt_o = miss_cnt_q;

    ibex_rf_opd_slot #(
        .DataWidth(DataWidth)
    ) u_slot_a (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (capture),
        .upd_en_i  (state_q == HOLD),
        .cap_addr_i(cap_addr_a),
        .cap_zero_i(cap_zero_a),
        .rf_rdata_i(rf_rdata_a_i),
        .wb_we_i   (wb_we_i),
        .wb_waddr_i(wb_waddr_i),
        .wb_wdata_i(wb_wdata_i),
        .data_o    (opd_a_o)
    );

    ibex_rf_opd_slot #(
        .DataWidth(DataWidth)
    ) u_slot_b (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (capture),
        .upd_en_i  (state_q == HOLD),
        .cap_addr_i(cap_addr_b),
        .cap_zero_i(cap_zero_b),
        .rf_rdata_i(rf_rdata_b_i),
        .wb_we_i   (wb_we_i),
        .wb_waddr_i(wb_waddr_i),
        .wb_wdata_i(wb_wdata_i),
        .data_o    (opd_b_o)
    );

endmodule

// File: tb/tb_ibex_rf_operand_fetch.sv
// Bench for the operand fetch stage: transaction-level model plus
// directed scenarios with literal expectations and a random phase.
module tb_ibex_rf_operand_fetch;

    localparam int DW      = 32;
    localparam int CW      = 8;
    localparam int CNT_MAX = 255;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i, req_ready_o;
    logic [4:0]    raddr_a_i, raddr_b_i;
    logic          use_b_i;
    logic [4:0]    rf_raddr_a_o, rf_raddr_b_o;
    logic [DW-1:0] rf_rdata_a_i, rf_rdata_b_i;
    logic          wb_we_i;
    logic [4:0]    wb_waddr_i;
    logic [DW-1:0] wb_wdata_i;
    logic          opd_valid_o, opd_ready_i;
    logic [DW-1:0] opd_a_o, opd_b_o;
    logic          stall_o;
    logic [CW-1:0] miss_cnt_o;

    int checks   = 0;
    int failures = 0;
    logic rd_override = 1'b0;

    ibex_rf_operand_fetch #(.DataWidth(DW), .CntWidth(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .raddr_a_i   (raddr_a_i),
        .raddr_b_i   (raddr_b_i),
        .use_b_i     (use_b_i),
        .rf_raddr_a_o(rf_raddr_a_o),
        .rf_raddr_b_o(rf_raddr_b_o),
        .rf_rdata_a_i(rf_rdata_a_i),
        .rf_rdata_b_i(rf_rdata_b_i),
        .wb_we_i     (wb_we_i),
        .wb_waddr_i  (wb_waddr_i),
        .wb_wdata_i  (wb_wdata_i),
        .opd_valid_o (opd_valid_o),
        .opd_ready_i (opd_ready_i),
        .opd_a_o     (opd_a_o),
        .opd_b_o     (opd_b_o),
        .stall_o     (stall_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic bit is_l2(input logic [4:0] a);
        return (a != 5'd0) && (a[4:3] != 2'b01);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Architectural register file; L2 entries read back garbage unless
    // the fetch is stalling for them.
    logic [DW-1:0] regs [32];

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {4{i[7:0]}};
        forever begin
            @(posedge clk);
            if (wb_we_i && wb_waddr_i != 5'd0) regs[wb_waddr_i] = wb_wdata_i;
        end
    end

    always_comb begin
        rf_rdata_a_i = regs[rf_raddr_a_o];
        rf_rdata_b_i = regs[rf_raddr_b_o];
        if (is_l2(rf_raddr_a_o) && !stall_o) rf_rdata_a_i = 32'hBAD0BAD0;
        if (is_l2(rf_raddr_b_o) && !stall_o) rf_rdata_b_i = 32'hBAD1BAD1;
        if (rd_override) begin
            rf_rdata_a_i = 32'hDEADBEEF;
            rf_rdata_b_i = 32'hDEADBEEF;
        end
    end

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic       ub;
        bit         l2;
        int         rdy;
    } txn_t;

    txn_t q[$];
    int   cyc = 0;
    int   miss = 0;

    always @(posedge clk or posedge rst_i) begin
        bit v, hs, acc, l2;
        if (rst_i) begin
            q.delete();
            miss = 0;
        end else begin
            v   = (q.size() > 0) && (cyc >= q[0].rdy);
            hs  = v && opd_ready_i;
            acc = req_valid_i && ((q.size() == 0) || hs);
            cyc++;
            if (hs) void'(q.pop_front());
            if (acc) begin
                l2 = is_l2(raddr_a_i) || (use_b_i && is_l2(raddr_b_i));
                q.push_back('{a: raddr_a_i, b: raddr_b_i, ub: use_b_i,
                              l2: l2, rdy: cyc + (l2 ? 1 : 0)});
                if (l2 && miss < CNT_MAX) miss++;
            end
        end
    end

    always @(negedge clk) begin
        bit ev, es, er;
        logic [DW-1:0] ea, eb;
        ev = !rst_i && (q.size() > 0) && (cyc >= q[0].rdy);
        es = !rst_i && (q.size() > 0) && q[0].l2 && (cyc == q[0].rdy - 1);
        er = !rst_i && ((q.size() == 0) || (ev && opd_ready_i));
        chk("opd_valid", opd_valid_o, ev);
        chk("stall", stall_o, es);
        chk("req_ready", req_ready_o, er);
        chk("miss_cnt", miss_cnt_o, miss);
        if (ev) begin
            ea = (q[0].a == 5'd0) ? '0 : regs[q[0].a];
            eb = (!q[0].ub || q[0].b == 5'd0) ? '0 : regs[q[0].b];
            chk("opd_a", opd_a_o, ea);
            chk("opd_b", opd_b_o, eb);
        end
        if (es) begin
            chk("rf_raddr_a_wait", rf_raddr_a_o, q[0].a);
            chk("rf_raddr_b_wait", rf_raddr_b_o, q[0].b);
        end
        if (rst_i) begin
            chk("rst_opd_a", opd_a_o, 0);
            chk("rst_opd_b", opd_b_o, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b,
                         input logic ub);
        req_valid_i = 1'b1;
        raddr_a_i   = a;
        raddr_b_i   = b;
        use_b_i     = ub;
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic handoff();
        opd_ready_i = 1'b1;
        step();
        opd_ready_i = 1'b0;
    endtask

    initial begin
        int w;
        rst_i       = 1'b1;
        req_valid_i = 1'b1;
        raddr_a_i   = 5'd9;
        raddr_b_i   = 5'd12;
        use_b_i     = 1'b1;
        wb_we_i     = 1'b0;
        wb_waddr_i  = '0;
        wb_wdata_i  = '0;
        opd_ready_i = 1'b0;

        @(negedge clk);
        chk("lit_rst_ready", req_ready_o, 0);
        chk("lit_rst_valid", opd_valid_o, 0);
        chk("lit_rst_miss", miss_cnt_o, 0);
        step();
        step();
        req_valid_i = 1'b0;
        rst_i       = 1'b0;
        step();

        issue(5'd9, 5'd12, 1'b1);
        @(negedge clk);
        chk("lit_l1_valid", opd_valid_o, 1);
        chk("lit_l1_stall", stall_o, 0);
        chk("lit_l1_a", opd_a_o, 32'h09090909);
        chk("lit_l1_b", opd_b_o, 32'h0C0C0C0C);
        chk("lit_l1_miss", miss_cnt_o, 0);
        handoff();

        issue(5'd5, 5'd9, 1'b1);
        @(negedge clk);
        chk("lit_l2_stall", stall_o, 1);
        chk("lit_l2_early", opd_valid_o, 0);
        step();
        @(negedge clk);
        chk("lit_l2_stall_end", stall_o, 0);
        chk("lit_l2_valid", opd_valid_o, 1);
        chk("lit_l2_a", opd_a_o, 32'h05050505);
        chk("lit_l2_b", opd_b_o, 32'h09090909);
        chk("lit_l2_miss", miss_cnt_o, 1);
        handoff();

        rd_override = 1'b1;
        issue(5'd0, 5'd20, 1'b0);
        @(negedge clk);
        chk("lit_zero_valid", opd_valid_o, 1);
        chk("lit_zero_stall", stall_o, 0);
        chk("lit_zero_a", opd_a_o, 0);
        chk("lit_zero_b", opd_b_o, 0);
        handoff();
        rd_override = 1'b0;

        issue(5'd5, 5'd9, 1'b1);
        wb_we_i    = 1'b1;
        wb_waddr_i = 5'd5;
        wb_wdata_i = 32'h12345678;
        step();
        wb_we_i = 1'b0;
        @(negedge clk);
        chk("lit_fwd_a", opd_a_o, 32'h12345678);
        chk("lit_fwd_miss", miss_cnt_o, 2);
        handoff();

        issue(5'd9, 5'd12, 1'b1);
        step();
        wb_we_i    = 1'b1;
        wb_waddr_i = 5'd12;
        wb_wdata_i = 32'hA5A5A5A5;
        @(negedge clk);
        chk("lit_hold_b_pre", opd_b_o, 32'h0C0C0C0C);
        step();
        wb_we_i = 1'b0;
        @(negedge clk);
        chk("lit_hold_valid", opd_valid_o, 1);
        chk("lit_hold_b", opd_b_o, 32'hA5A5A5A5);
        chk("lit_hold_a", opd_a_o, 32'h09090909);
        handoff();

        issue(5'd5, 5'd9, 1'b1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("lit_abort_valid", opd_valid_o, 0);
        chk("lit_abort_stall", stall_o, 0);
        chk("lit_abort_miss", miss_cnt_o, 0);
        step();
        rst_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("lit_abort_nodeliver", opd_valid_o, 0);
            step();
        end

        opd_ready_i = 1'b1;
        req_valid_i = 1'b1;
        raddr_a_i   = 5'd5;
        use_b_i     = 1'b1;
        for (int n = 0; n < 300; n++) begin
            w = 0;
            while (!req_ready_o && w < 8) begin
                step();
                w++;
            end
            if (w == 8) chk("ready_timeout", req_ready_o, 1);
            raddr_b_i = 5'($urandom_range(0, 31));
            step();
        end
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("lit_sat_miss", miss_cnt_o, 8'hFF);
        step();
        step();

        for (int c = 0; c < 3000; c++) begin
            rst_i       = ($urandom_range(0, 499) == 0);
            req_valid_i = ($urandom_range(0, 3) != 0);
            raddr_a_i   = 5'($urandom_range(0, 31));
            raddr_b_i   = 5'($urandom_range(0, 31));
            use_b_i     = ($urandom_range(0, 3) != 0);
            opd_ready_i = ($urandom_range(0, 2) != 0);
            wb_we_i     = ($urandom_range(0, 9) < 4);
            wb_waddr_i  = 5'($urandom_range(0, 31));
            wb_wdata_i  = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
